mul_pipe_stage: RTL and testbench
=================================

MUL_PIPE_STAGE -- requirements
Module: mul_pipe_stage

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter WIDTH, default 16: operand and result width in bits, legal range 4..32.
REQ-002 The block SHALL have parameter FRAC_BITS, default 8: fractional bits of the signed fixed-point format, legal range 1..WIDTH-1.
REQ-003 The block SHALL have parameter STAGES, default 3: pipeline depth in register stages, legal range 1..8.
REQ-004 The block SHALL have parameter SATURATE, default 1: 1 means clamp on overflow; 0 means wrap (truncate upper bits).

Ports (name, direction, width, meaning):
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port srcReady, input, 1 bit: upstream holds a valid operand pair.
REQ-008 The block SHALL have port readyForInput, output, 1 bit: the block accepts a pair this cycle.
REQ-009 The block SHALL have port in_A, input, WIDTH bits: signed fixed-point operand A.
REQ-010 The block SHALL have port in_B, input, WIDTH bits: signed fixed-point operand B.
REQ-011 The block SHALL have port outputReady, output, 1 bit: multiplicationResult is valid.
REQ-012 The block SHALL have port destReady, input, 1 bit: downstream accepts the result this cycle.
REQ-013 The block SHALL have port multiplicationResult, output, WIDTH bits: the signed fixed-point product.
REQ-014 The block SHALL have port overflow, output, 1 bit: sticky flag, set when any result was clamped or wrapped.
REQ-015 The block SHALL have port clrOverflow, input, 1 bit: synchronous clear of the overflow flag.

Function
REQ-016 Transfers SHALL occur only on rising clk edges.
  - An input transfer happens when srcReady=1 and readyForInput=1.
  - An output transfer happens when outputReady=1 and destReady=1.
REQ-017 The pipeline SHALL advance when en = !outputReady || destReady; readyForInput SHALL equal en (global stall, no bubble collapse).
REQ-018 Each stage SHALL carry a valid bit.
  - Stage 0 loads the valid bit (srcReady AND en) while en=1.
  - All stages hold their contents while en=0.
REQ-019 outputReady SHALL equal the valid bit of the last stage.
  - Without stalls, the result appears exactly STAGES cycles after the input transfer.
  - Throughput SHALL be one pair per cycle.
REQ-020 The arithmetic SHALL proceed as follows:
  - Form the full 2*WIDTH-bit signed product A*B.
  - Add 2^(FRAC_BITS-1) (round half up).
  - Arithmetic-shift right by FRAC_BITS.
  - Reduce to WIDTH bits.
REQ-021 With SATURATE=1, a shifted value above 2^(WIDTH-1)-1 SHALL yield the maximum positive value, and a value below -2^(WIDTH-1) SHALL yield the minimum negative value.
REQ-022 With SATURATE=0, the result SHALL be the low WIDTH bits of the shifted value.
REQ-023 An out-of-range result SHALL set overflow in the cycle that result becomes the last-stage value, whether SATURATE is 1 or 0.
REQ-024 clrOverflow=1 SHALL clear overflow at the next edge; a simultaneous new overflow event SHALL win, leaving overflow=1.
REQ-025 multiplicationResult SHALL hold its value while outputReady=1 and destReady=0 (stall).
  - It SHALL NOT change until the transfer completes.
REQ-026 Operands presented while readyForInput=0 SHALL be ignored; upstream must hold them until accepted.
REQ-027 The register placement of the product and rounding logic across stages is implementation-defined; only latency and results are normative.

Reset
REQ-028 When rst=0, asynchronously and independent of clk, the block SHALL:
  - clear all stage valid bits;
  - drive outputReady=0, overflow=0, multiplicationResult=0.
REQ-029 While rst=0, readyForInput SHALL read 1 (en=1, since the pipe is empty), but no transfer SHALL be captured.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight pairs; no stale result SHALL appear after release.
REQ-031 The first edge after rst rises SHALL accept input normally.

Verification (WIDTH=16, FRAC_BITS=8, STAGES=3, SATURATE=1 unless stated)
REQ-032 The bench SHALL cover basic latency.
  - Stimulus: A=0x0100, B=0x0100, destReady=1.
  - Required: outputReady rises 3 edges later with result 0x0100, overflow=0.
REQ-033 The bench SHALL cover sign and rounding.
  - Stimulus: pair 0xFF00*0x0180, then pair 0x0001*0x0080, back-to-back.
  - Required: results 0xFE80, then 0x0001, on consecutive cycles.
REQ-034 The bench SHALL cover saturation and the sticky flag.
  - Stimulus: 0x7FFF*0x0200.
  - Required: result 0x7FFF and overflow=1, holding until clrOverflow pulses.
  - Repeat with SATURATE=0: result 0xFFFE, overflow=1.
REQ-035 The bench SHALL cover backpressure.
  - Stimulus: stream 5 pairs with destReady=0 for 4 cycles after the first result.
  - Required: readyForInput=0 during the stall, the output is stable, and all 5 results arrive in order with none lost or duplicated.
REQ-036 The bench SHALL cover reset mid-flight.
  - Stimulus: 2 pairs in the pipe, then rst=0 between clock edges.
  - Required: outputReady=0 and result 0x0000 immediately; no output after release until new input.
REQ-037 The bench SHALL cover overflow clear versus set.
  - Stimulus: clrOverflow=1 in the same cycle a saturating result reaches the last stage.
  - Required: overflow remains 1.

Source files
------------

// File: rtl/mul_pipe_stage.sv
// Pipelined signed fixed-point multiplier with round-half-up,
// optional saturation and a sticky overflow flag.
module mul_pipe_stage #(
  parameter int WIDTH     = 16,
  parameter int FRAC_BITS = 8,
  parameter int STAGES    = 3,
  parameter int SATURATE  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             srcReady,
  output logic             readyForInput,
  input  logic [WIDTH-1:0] in_A,
  input  logic [WIDTH-1:0] in_B,
  output logic             outputReady,
  input  logic             destReady,
  output logic [WIDTH-1:0] multiplicationResult,
  output logic             overflow,
  input  logic             clrOverflow
);

  localparam int PW = 2 * WIDTH + 1;
  localparam int L  = STAGES - 1;

  localparam logic signed [PW-1:0] HALF =
    PW'(64'sd1 <<< (FRAC_BITS - 1));
  localparam logic signed [PW-1:0] MAXV =
    PW'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
  localparam logic signed [PW-1:0] MINV =
    PW'(-(64'sd1 <<< (WIDTH - 1)));

  logic signed [2*WIDTH-1:0] prod;
  logic signed [PW-1:0]      rnd;
  logic signed [PW-1:0]      shf;
  logic [WIDTH-1:0]          res;
  logic                      oor;
  logic                      en;
  logic                      last_ovf;

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] nvld;
  logic [WIDTH-1:0]  dat  [STAGES];
  logic [WIDTH-1:0]  ndat [STAGES];

  // global stall: the whole pipe moves only when the tail can drain
  assign en            = !vld[L] || destReady;
  assign readyForInput = en;
  assign outputReady   = vld[L];
  assign multiplicationResult = dat[L];

  // full product, round half up, rescale, then clamp or wrap
  always_comb begin
    prod = $signed(in_A) * $signed(in_B);
    rnd  = {prod[2*WIDTH-1], prod} + HALF;
    shf  = rnd >>> FRAC_BITS;
    oor  = (shf > MAXV) || (shf < MINV);
    res  = shf[WIDTH-1:0];
    if (SATURATE != 0) begin
      if (shf > MAXV) res = MAXV[WIDTH-1:0];
      else if (shf < MINV) res = MINV[WIDTH-1:0];
    end
  end

  // next-state view of every stage: head takes the new result
  always_comb begin
    nvld    = '0;
    nvld[0] = srcReady;
    for (int i = 0; i < STAGES; i++) ndat[i] = '0;
    ndat[0] = res;
    for (int i = 1; i < STAGES; i++) begin
      nvld[i] = vld[i-1];
      ndat[i] = dat[i-1];
    end
  end

  // stage registers: shift on enable, hold on stall
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld <= '0;
      for (int i = 0; i < STAGES; i++) dat[i] <= '0;
    end else if (en) begin
      vld <= nvld;
      for (int i = 0; i < STAGES; i++) dat[i] <= ndat[i];
    end
  end

  // range flag travels beside the data up to the last stage
  if (STAGES > 1) begin : g_ovf
    logic [STAGES-2:0] ovf;
    // out-of-range bits for stages ahead of the tail
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        ovf <= '0;
      end else if (en) begin
        for (int i = STAGES - 2; i > 0; i--) ovf[i] <= ovf[i-1];
        ovf[0] <= oor;
      end
    end
    assign last_ovf = ovf[STAGES-2];
  end else begin : g_no_ovf
    assign last_ovf = oor;
  end

  // sticky flag: a new event beats a simultaneous clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (en && nvld[L] && last_ovf) begin
      overflow <= 1'b1;
    end else if (clrOverflow) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mul_pipe_stage.sv
// Scoreboard bench for mul_pipe_stage: a saturating and a
// wrapping instance share stimulus; a monitor checks results.
module tb_mul_pipe_stage;

  logic        clk;
  logic        rst;
  logic        srcReady;
  logic        destReady;
  logic        clrOverflow;
  logic [15:0] in_A;
  logic [15:0] in_B;

  logic        rdy0, rdy1;
  logic        ord0, ord1;
  logic [15:0] res0, res1;
  logic        ov0, ov1;

  typedef struct packed {
    logic [15:0] s;
    logic [15:0] w;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_pop = 0;
  int   prev_pop = 0;

  mul_pipe_stage #(
    .WIDTH(16), .FRAC_BITS(8), .STAGES(3), .SATURATE(1)
  ) dut_sat (
    .clk(clk), .rst(rst), .srcReady(srcReady),
    .readyForInput(rdy0), .in_A(in_A), .in_B(in_B),
    .outputReady(ord0), .destReady(destReady),
    .multiplicationResult(res0), .overflow(ov0),
    .clrOverflow(clrOverflow)
  );

  mul_pipe_stage #(
    .WIDTH(16), .FRAC_BITS(8), .STAGES(3), .SATURATE(0)
  ) dut_wrap (
    .clk(clk), .rst(rst), .srcReady(srcReady),
    .readyForInput(rdy1), .in_A(in_A), .in_B(in_B),
    .outputReady(ord1), .destReady(destReady),
    .multiplicationResult(res1), .overflow(ov1),
    .clrOverflow(clrOverflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // monitor: every output transfer pops one expected entry
  always @(negedge clk) begin
    if (rst === 1'b1 && ord0 && destReady) begin
      if (q.size() == 0) begin
        chk("unexpected_output", {16'h0, res0}, 32'hdead);
      end else begin
        e = q.pop_front();
        chk("result_sat", {16'h0, res0}, {16'h0, e.s});
        chk("result_wrap", {16'h0, res1}, {16'h0, e.w});
        chk("valid_wrap", {31'h0, ord1}, 32'h1);
      end
      prev_pop = last_pop;
      last_pop = cyc;
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] s, input logic [15:0] w);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    in_A = a;
    in_B = b;
    srcReady = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (rdy0) begin
        q.push_back('{s: s, w: w});
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #1 srcReady = 1'b0;
    if (!ok) chk("send_timeout", 32'h0, 32'h1);
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && q.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    chk("drain_empty", q.size(), 32'h0);
  endtask

  task automatic stall4();
    logic [15:0] held;
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (ord0) begin
        seen = 1'b1;
        break;
      end
    end
    chk("stall_saw_output", {31'h0, seen}, 32'h1);
    destReady = 1'b0;
    held = res0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stall_ready_low", {30'h0, rdy0, rdy1}, 32'h0);
      chk("stall_valid_held", {31'h0, ord0}, 32'h1);
      chk("stall_result_held", {16'h0, res0}, {16'h0, held});
    end
    @(posedge clk);
    #1 destReady = 1'b1;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    srcReady = 1'b0;
    destReady = 1'b1;
    clrOverflow = 1'b0;
    in_A = 16'h0100;
    in_B = 16'h0100;
    #2 rst = 1'b0;
    srcReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", {31'h0, ord0}, 32'h0);
    chk("reset_result", {16'h0, res0}, 32'h0);
    chk("reset_overflow", {31'h0, ov0}, 32'h0);
    chk("reset_ready", {31'h0, rdy0}, 32'h1);
    srcReady = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("no_capture_in_reset", {31'h0, ord0}, 32'h0);

    // basic latency: capture edge plus two more
    send(16'h0100, 16'h0100, 16'h0100, 16'h0100);
    n = 1;
    while (!ord0 && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency_edges", n, 32'd3);
    chk("latency_overflow", {31'h0, ov0}, 32'h0);
    drain();

    // sign and rounding, back to back
    send(16'hFF00, 16'h0180, 16'hFE80, 16'hFE80);
    send(16'h0001, 16'h0080, 16'h0001, 16'h0001);
    drain();
    chk("b2b_consecutive", last_pop - prev_pop, 32'd1);
    chk("sign_no_overflow", {30'h0, ov0, ov1}, 32'h0);

    // saturation vs wrap, sticky until cleared
    send(16'h7FFF, 16'h0200, 16'h7FFF, 16'hFFFE);
    drain();
    chk("sat_overflow", {31'h0, ov0}, 32'h1);
    chk("wrap_overflow", {31'h0, ov1}, 32'h1);
    repeat (3) @(negedge clk);
    chk("overflow_sticky", {30'h0, ov0, ov1}, 32'h3);
    clrOverflow = 1'b1;
    @(negedge clk);
    clrOverflow = 1'b0;
    chk("overflow_cleared", {30'h0, ov0, ov1}, 32'h0);

    // backpressure with a 4-cycle downstream stall
    fork
      begin
        send(16'h0200, 16'h0300, 16'h0600, 16'h0600);
        send(16'h0080, 16'h0080, 16'h0040, 16'h0040);
        send(16'hFF80, 16'h0200, 16'hFF00, 16'hFF00);
        send(16'h0003, 16'h0055, 16'h0001, 16'h0001);
        send(16'h0100, 16'hFFFF, 16'hFFFF, 16'hFFFF);
      end
      stall4();
    join
    drain();

    // clear and new overflow in the same cycle
    send(16'h7FFF, 16'h0200, 16'h7FFF, 16'hFFFE);
    chk("race_pre_overflow", {31'h0, ov0}, 32'h0);
    @(posedge clk);
    #1 clrOverflow = 1'b1;
    @(posedge clk);
    #1 clrOverflow = 1'b0;
    chk("race_tail_valid", {31'h0, ord0}, 32'h1);
    chk("race_set_wins", {30'h0, ov0, ov1}, 32'h3);
    drain();

    // reset with two pairs in flight
    send(16'h0200, 16'h0200, 16'h0400, 16'h0400);
    send(16'h0300, 16'h0100, 16'h0300, 16'h0300);
    #1 rst = 1'b0;
    #1;
    chk("midreset_valid", {31'h0, ord0}, 32'h0);
    chk("midreset_result", {16'h0, res0}, 32'h0);
    chk("midreset_overflow", {31'h0, ov0}, 32'h0);
    q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("no_stale_output", {30'h0, ord0, ord1}, 32'h0);

    send(16'h0200, 16'h0300, 16'h0600, 16'h0600);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
